// File: rtl/riscv_defines_pkg.sv
// Shared definitions for the load/store path: memory geometry, access size
// encoding, LSU state encoding and the alignment rule.
package riscv_defines_pkg;

  localparam int MEM_ADDR_WIDTH = 10;
  localparam int MEM_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    LSU_BYTE = 2'b00,
    LSU_HALF = 2'b01,
    LSU_WORD = 2'b10,
    LSU_RSVD = 2'b11
  } lsu_size_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RD   = 2'b01,
    WR   = 2'b10,
    RESP = 2'b11
  } lsu_state_t;

  // The reserved size code is always rejected, whatever the address.
  function automatic logic lsu_misaligned(input lsu_size_t size, input logic [1:0] addr_lo);
    logic mis;
    case (size)
      LSU_BYTE: mis = 1'b0;
      LSU_HALF: mis = addr_lo[0];
      LSU_WORD: mis = |addr_lo;
      default:  mis = 1'b1;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane handling: extracts and extends a load lane, and merges
// store data into the surrounding memory word (little-endian lanes).
module lsu_align
  import riscv_defines_pkg::*;
(
  input  lsu_size_t   size_i,
  input  logic        unsigned_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] mem_word_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_data_o,
  output logic [31:0] merged_o
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    case (addr_lo_i)
      2'd0:    byte_lane = mem_word_i[7:0];
      2'd1:    byte_lane = mem_word_i[15:8];
      2'd2:    byte_lane = mem_word_i[23:16];
      default: byte_lane = mem_word_i[31:24];
    endcase
    half_lane = addr_lo_i[1] ? mem_word_i[31:16] : mem_word_i[15:0];

    load_data_o = mem_word_i;
    merged_o    = mem_word_i;
    case (size_i)
      LSU_BYTE: begin
        load_data_o = unsigned_i ? {24'h0, byte_lane} : {{24{byte_lane[7]}}, byte_lane};
        case (addr_lo_i)
          2'd0:    merged_o[7:0]   = wdata_i[7:0];
          2'd1:    merged_o[15:8]  = wdata_i[7:0];
          2'd2:    merged_o[23:16] = wdata_i[7:0];
          default: merged_o[31:24] = wdata_i[7:0];
        endcase
      end
      LSU_HALF: begin
        load_data_o = unsigned_i ? {16'h0, half_lane} : {{16{half_lane[15]}}, half_lane};
        if (addr_lo_i[1]) merged_o[31:16] = wdata_i[15:0];
        else              merged_o[15:0]  = wdata_i[15:0];
      end
      LSU_WORD: merged_o = wdata_i;
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit in front of a word-wide memory with
// combinational read; sub-word stores are done as read-modify-write.
module load_store_unit
  import riscv_defines_pkg::*;
#(
  parameter int WORD_ADDR_BITS = MEM_ADDR_WIDTH
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_rw,
  input  logic [31:0] mem_rdata
);

  lsu_state_t                state_q;
  logic                      we_q;
  logic                      uns_q;
  logic                      err_q;
  lsu_size_t                 size_q;
  logic [WORD_ADDR_BITS+1:0] addr_q;
  logic [31:0]               wdata_q;
  logic [31:0]               rdata_q;

  logic [31:0] load_data;
  logic [31:0] merged_word;
  logic        req_mis;
  logic        addr_unused;

  // Address bits above the memory's word index wrap away.
  assign addr_unused = ^req_addr[31:WORD_ADDR_BITS+2];
  assign req_mis     = lsu_misaligned(lsu_size_t'(req_size), req_addr[1:0]);

  lsu_align u_align (
    .size_i      (size_q),
    .unsigned_i  (uns_q),
    .addr_lo_i   (addr_q[1:0]),
    .mem_word_i  (mem_rdata),
    .wdata_i     (wdata_q),
    .load_data_o (load_data),
    .merged_o    (merged_word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= LSU_BYTE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            uns_q   <= req_unsigned;
            size_q  <= lsu_size_t'(req_size);
            addr_q  <= req_addr[WORD_ADDR_BITS+1:0];
            wdata_q <= req_wdata;
            rdata_q <= '0;
            err_q   <= req_mis;
            if (req_mis)                                  state_q <= RESP;
            else if (req_we && (req_size == 2'b10))       state_q <= WR;
            else                                          state_q <= RD;
          end
        end
        RD: begin
          // Sub-word stores fold the merged word back into the write-data register.
          if (we_q) begin
            wdata_q <= merged_word;
            state_q <= WR;
          end else begin
            rdata_q <= load_data;
            state_q <= RESP;
          end
        end
        WR:      state_q <= RESP;
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready  = (state_q == IDLE) && !rst;
  assign mem_rw     = (state_q == WR) && !rst;
  assign mem_wdata  = mem_rw ? wdata_q : '0;
  assign mem_addr   = ((state_q != IDLE) && !rst)
                    ? {{(32-WORD_ADDR_BITS){1'b0}}, addr_q[WORD_ADDR_BITS+1:2]} : '0;
  assign resp_valid = (state_q == RESP) && !rst;
  assign resp_err   = resp_valid && err_q;
  assign resp_rdata = resp_valid ? rdata_q : '0;

endmodule
